// File: rtl/exec_mem_pkg.sv
// exec_mem_pkg: opcode/funct codes and control encodings for the MIPS-lite exec/mem datapath
package exec_mem_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_PASSB} aluop_e;
  typedef enum logic [2:0] {DM_W, DM_HS, DM_HU, DM_BS, DM_BU} dmop_e;
  localparam logic [1:0] PC_NEXT = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_JR = 2'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
endpackage

// File: rtl/exec_mem_if.sv
// exec_mem_if: operand/result bundle between the GRF side and the exec/mem datapath
interface exec_mem_if;
  logic [5:0] opcode, funct;
  logic [31:0] rs_data, rt_data, ext_imm, pc, alu_res, rd_data;
  logic zero, regwrite, alusrc;
  logic [1:0] memtoreg, regdst, pcsrc, extop;
  modport master (output opcode, funct, rs_data, rt_data, ext_imm, pc,
                  input alu_res, zero, rd_data, memtoreg, regdst, regwrite, alusrc, pcsrc, extop);
  modport slave (input opcode, funct, rs_data, rt_data, ext_imm, pc,
                 output alu_res, zero, rd_data, memtoreg, regdst, regwrite, alusrc, pcsrc, extop);
endinterface

// File: rtl/exec_mem_unit_dm_ram.sv
// dm_ram: word array with byte-lane writes, sync clear and comb read; EXEC_MEM_TRACE_EN prints committed stores
module dm_ram #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rword
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0] mem [DM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] nword;
  logic unused_bits;
  assign idx = addr[AW+1:2];
  assign rword = mem[idx];
  assign unused_bits = ^{pc, addr};
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign nword[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rword[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    else if (we) mem[idx] <= nword;
  end
`ifdef EXEC_MEM_TRACE_EN
  always_ff @(posedge clk) if (!reset && we) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, nword);
`else
`endif
endmodule

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: MIPS-lite main decoder, ALU and data memory; EXEC_MEM_TRACE_EN enables store trace
module exec_mem_unit
  import exec_mem_pkg::*;
#(
  parameter int DM_WORDS = 1024
) (
  input logic clk,
  input logic reset,
  exec_mem_if.slave bus
);
  aluop_e aluop;
  dmop_e dmop;
  logic memwrite, regwrite, alusrc, branch;
  logic [1:0] memtoreg, regdst, pcsel, extop;
  logic [31:0] b, res, rword, wdata, half_ext, byte_ext;
  logic [3:0] be;
  logic [15:0] half;
  logic [7:0] byt;
  logic is_half, is_byte;
  always_comb begin
    aluop = ALU_ADD;
    memwrite = 1'b0;
    regwrite = 1'b0;
    alusrc = 1'b0;
    branch = 1'b0;
    memtoreg = WB_ALU;
    regdst = RD_RT;
    pcsel = PC_NEXT;
    extop = EXT_ZERO;
    case (bus.opcode)
      OP_R: begin
        regdst = RD_RD;
        regwrite = bus.funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU};
        pcsel = bus.funct == FN_JR ? PC_JR : PC_NEXT;
        aluop = bus.funct == FN_SUBU ? ALU_SUB : bus.funct == FN_AND ? ALU_AND : bus.funct == FN_OR ? ALU_OR :
                bus.funct == FN_SLT ? ALU_SLT : bus.funct == FN_SLTU ? ALU_SLTU : ALU_ADD;
      end
      OP_ADDIU: begin regwrite = 1'b1; alusrc = 1'b1; extop = EXT_SIGN; end
      OP_ORI: begin regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_OR; end
      OP_LUI: begin regwrite = 1'b1; alusrc = 1'b1; extop = EXT_LUI; aluop = ALU_PASSB; end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin regwrite = 1'b1; alusrc = 1'b1; extop = EXT_SIGN; memtoreg = WB_MEM; end
      OP_SW, OP_SH, OP_SB: begin memwrite = 1'b1; alusrc = 1'b1; extop = EXT_SIGN; end
      OP_BEQ: begin branch = 1'b1; aluop = ALU_SUB; extop = EXT_SIGN; pcsel = PC_BR; end
      OP_J: pcsel = PC_JMP;
      OP_JAL: begin pcsel = PC_JMP; regdst = RD_RA; memtoreg = WB_PC4; regwrite = 1'b1; end
      default: ;
    endcase
  end
  assign dmop = bus.opcode inside {OP_LH, OP_SH} ? DM_HS : bus.opcode == OP_LHU ? DM_HU :
                bus.opcode inside {OP_LB, OP_SB} ? DM_BS : bus.opcode == OP_LBU ? DM_BU : DM_W;
  assign b = alusrc ? bus.ext_imm : bus.rt_data;
  always_comb begin
    res = bus.rs_data + b;
    case (aluop)
      ALU_SUB: res = bus.rs_data - b;
      ALU_OR: res = bus.rs_data | b;
      ALU_AND: res = bus.rs_data & b;
      ALU_SLT: res = {31'd0, $signed(bus.rs_data) < $signed(b)};
      ALU_SLTU: res = {31'd0, bus.rs_data < b};
      ALU_XOR: res = bus.rs_data ^ b;
      ALU_PASSB: res = b;
      default: ;
    endcase
  end
  assign is_half = dmop inside {DM_HS, DM_HU};
  assign is_byte = dmop inside {DM_BS, DM_BU};
  assign be = is_half ? (res[1] ? 4'b1100 : 4'b0011) : is_byte ? 4'b0001 << res[1:0] : 4'b1111;
  assign wdata = is_half ? {2{bus.rt_data[15:0]}} : is_byte ? {4{bus.rt_data[7:0]}} : bus.rt_data;
  dm_ram #(.DM_WORDS(DM_WORDS)) u_dm (
    .clk(clk), .reset(reset), .we(memwrite), .be(be), .addr(res),
    .wdata(wdata), .pc(bus.pc), .rword(rword)
  );
  assign half = res[1] ? rword[31:16] : rword[15:0];
  assign byt = rword[{res[1:0], 3'b000} +: 8];
  assign half_ext = {{16{dmop == DM_HS && half[15]}}, half};
  assign byte_ext = {{24{dmop == DM_BS && byt[7]}}, byt};
  assign bus.rd_data = is_half ? half_ext : is_byte ? byte_ext : rword;
  assign bus.alu_res = res;
  assign bus.zero = res == 32'd0;
  assign bus.pcsrc = branch && res != 32'd0 ? PC_NEXT : pcsel;
  assign bus.memtoreg = memtoreg;
  assign bus.regdst = regdst;
  assign bus.regwrite = regwrite;
  assign bus.alusrc = alusrc;
  assign bus.extop = extop;
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: directed vectors with queued expectations checked by a negedge monitor
module tb_exec_mem_unit;
  typedef struct {
    string nm;
    logic [8:0] m;
    logic [31:0] alu, rd;
    logic z, rw, as;
    logic [1:0] mtr, rdst, pcs, ext;
  } exp_t;
  localparam logic [8:0] M_ALU = 9'h001, M_Z = 9'h002, M_RD = 9'h004, M_MTR = 9'h008, M_RDST = 9'h010;
  localparam logic [8:0] M_RW = 9'h020, M_AS = 9'h040, M_PCS = 9'h080, M_EXT = 9'h100, M_ALL = 9'h1ff;
  localparam logic [8:0] M_R = M_ALL & ~(M_RD | M_EXT);
  localparam logic [8:0] M_ST = M_ALU | M_RD | M_RW | M_PCS;
  localparam logic [8:0] M_LD = M_ALU | M_RD | M_MTR | M_RW;
  localparam logic [8:0] M_JMP = M_RW | M_PCS;
  localparam logic [8:0] M_BR = M_ALU | M_Z | M_RW | M_AS | M_PCS;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vld = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t cur;
  exec_mem_if bus();
  exec_mem_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic exp_t mk(string nm, logic [8:0] m, logic [31:0] alu, logic z, logic [31:0] rd,
                              logic [1:0] mtr, logic [1:0] rdst, logic rw, logic as, logic [1:0] pcs, logic [1:0] ext);
    exp_t e;
    e.nm = nm; e.m = m; e.alu = alu; e.z = z; e.rd = rd; e.mtr = mtr;
    e.rdst = rdst; e.rw = rw; e.as = as; e.pcs = pcs; e.ext = ext;
    return e;
  endfunction
  task automatic cmp(string nm, string f, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s.%s got %h expected %h", nm, f, a, e);
    end
  endtask
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic r, input exp_t e);
    @(posedge clk);
    #1;
    reset = r;
    bus.opcode = op; bus.funct = fn; bus.rs_data = rs; bus.rt_data = rt; bus.ext_imm = imm; bus.pc = 32'h3000 + 32'(q.size());
    q.push_back(e);
    vld = 1'b1;
  endtask
  always @(negedge clk) begin
    if (vld) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard underflow got output expected none");
      end else begin
        cur = q.pop_front();
        if (cur.m[0]) cmp(cur.nm, "alu_res", bus.alu_res, cur.alu);
        if (cur.m[1]) cmp(cur.nm, "zero", 32'(bus.zero), 32'(cur.z));
        if (cur.m[2]) cmp(cur.nm, "rd_data", bus.rd_data, cur.rd);
        if (cur.m[3]) cmp(cur.nm, "memtoreg", 32'(bus.memtoreg), 32'(cur.mtr));
        if (cur.m[4]) cmp(cur.nm, "regdst", 32'(bus.regdst), 32'(cur.rdst));
        if (cur.m[5]) cmp(cur.nm, "regwrite", 32'(bus.regwrite), 32'(cur.rw));
        if (cur.m[6]) cmp(cur.nm, "alusrc", 32'(bus.alusrc), 32'(cur.as));
        if (cur.m[7]) cmp(cur.nm, "pcsrc", 32'(bus.pcsrc), 32'(cur.pcs));
        if (cur.m[8]) cmp(cur.nm, "extop", 32'(bus.extop), 32'(cur.ext));
      end
    end
  end
  initial begin
    bus.opcode = '0; bus.funct = '0; bus.rs_data = '0; bus.rt_data = '0; bus.ext_imm = '0; bus.pc = '0;
    repeat (2) @(posedge clk);
    issue(6'h23, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, mk("rst_lw0", M_ALL, 32'h0, 1, 32'h0, 1, 0, 1, 1, 0, 1));
    issue(6'h23, 6'h00, 32'h8, 32'h0, 32'h0, 1'b0, mk("rst_lw8", M_ALL, 32'h8, 0, 32'h0, 1, 0, 1, 1, 0, 1));
    issue(6'h00, 6'h21, 32'h7fffffff, 32'h1, 32'h0, 1'b0, mk("addu", M_R, 32'h80000000, 0, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h00, 6'h23, 32'h5, 32'h7, 32'h0, 1'b0, mk("subu", M_R, 32'hfffffffe, 0, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h00, 6'h24, 32'hf0f0, 32'hff00, 32'h0, 1'b0, mk("and", M_R, 32'hf000, 0, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h00, 6'h25, 32'hf0f0, 32'hff00, 32'h0, 1'b0, mk("or", M_R, 32'hfff0, 0, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h00, 6'h2a, 32'hffffffff, 32'h1, 32'h0, 1'b0, mk("slt", M_R, 32'h1, 0, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h00, 6'h2b, 32'hffffffff, 32'h1, 32'h0, 1'b0, mk("sltu", M_R, 32'h0, 1, 0, 0, 1, 1, 0, 0, 0));
    issue(6'h0d, 6'h00, 32'h12340000, 32'h0, 32'h0000ffff, 1'b0, mk("ori", M_ALL & ~M_RD, 32'h1234ffff, 0, 0, 0, 0, 1, 1, 0, 0));
    issue(6'h09, 6'h00, 32'h10, 32'h0, 32'hffffffff, 1'b0, mk("addiu", M_ALL & ~M_RD, 32'hf, 0, 0, 0, 0, 1, 1, 0, 1));
    issue(6'h0f, 6'h00, 32'h1234, 32'h0, 32'habcd0000, 1'b0, mk("lui", M_ALL & ~M_RD, 32'habcd0000, 0, 0, 0, 0, 1, 1, 0, 2));
    issue(6'h04, 6'h00, 32'h5, 32'h5, 32'h0, 1'b0, mk("beq_t", M_BR, 32'h0, 1, 0, 0, 0, 0, 0, 1, 0));
    issue(6'h04, 6'h00, 32'h5, 32'h6, 32'h0, 1'b0, mk("beq_nt", M_BR, 32'hffffffff, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(6'h02, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, mk("j", M_JMP, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    issue(6'h03, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, mk("jal", M_JMP | M_MTR | M_RDST, 0, 0, 0, 2, 2, 1, 0, 2, 0));
    issue(6'h00, 6'h08, 32'h400, 32'h0, 32'h0, 1'b0, mk("jr", M_JMP, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    issue(6'h00, 6'h00, 32'h1, 32'h2, 32'h0, 1'b0, mk("nop", M_JMP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(6'h00, 6'h3f, 32'h1, 32'h2, 32'h0, 1'b0, mk("bad_fn", M_JMP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(6'h2b, 6'h00, 32'h8, 32'h11223344, 32'h0, 1'b0, mk("sw8", M_ST, 32'h8, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    issue(6'h28, 6'h00, 32'h9, 32'h123456aa, 32'h0, 1'b0, mk("sb9", M_ST, 32'h9, 0, 32'h33, 0, 0, 0, 0, 0, 0));
    issue(6'h23, 6'h00, 32'h8, 32'h0, 32'h0, 1'b0, mk("lw8", M_LD, 32'h8, 0, 32'h1122aa44, 1, 0, 1, 0, 0, 0));
    issue(6'h20, 6'h00, 32'h9, 32'h0, 32'h0, 1'b0, mk("lb9", M_LD, 32'h9, 0, 32'hffffffaa, 1, 0, 1, 0, 0, 0));
    issue(6'h24, 6'h00, 32'h9, 32'h0, 32'h0, 1'b0, mk("lbu9", M_LD, 32'h9, 0, 32'h000000aa, 1, 0, 1, 0, 0, 0));
    issue(6'h29, 6'h00, 32'he, 32'h00008001, 32'h0, 1'b0, mk("she", M_ST, 32'he, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    issue(6'h21, 6'h00, 32'he, 32'h0, 32'h0, 1'b0, mk("lhe", M_LD, 32'he, 0, 32'hffff8001, 1, 0, 1, 0, 0, 0));
    issue(6'h25, 6'h00, 32'he, 32'h0, 32'h0, 1'b0, mk("lhue", M_LD, 32'he, 0, 32'h00008001, 1, 0, 1, 0, 0, 0));
    issue(6'h21, 6'h00, 32'hf, 32'h0, 32'h0, 1'b0, mk("lhf", M_LD, 32'hf, 0, 32'hffff8001, 1, 0, 1, 0, 0, 0));
    issue(6'h23, 6'h00, 32'hc, 32'h0, 32'h0, 1'b0, mk("lwc", M_LD, 32'hc, 0, 32'h80010000, 1, 0, 1, 0, 0, 0));
    issue(6'h2b, 6'h00, 32'h1000, 32'hdeadbeef, 32'h0, 1'b0, mk("sw_alias", M_ST, 32'h1000, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    issue(6'h23, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, mk("lw_alias", M_LD, 32'h0, 0, 32'hdeadbeef, 1, 0, 1, 0, 0, 0));
    issue(6'h2b, 6'h00, 32'h0, 32'h55, 32'h0, 1'b1, mk("sw_rst", M_ALU | M_RW, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(6'h23, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, mk("lw0_cleared", M_LD, 32'h0, 0, 32'h0, 1, 0, 1, 0, 0, 0));
    issue(6'h23, 6'h00, 32'h8, 32'h0, 32'h0, 1'b0, mk("lw8_cleared", M_LD, 32'h8, 0, 32'h0, 1, 0, 1, 0, 0, 0));
    issue(6'h3f, 6'h00, 32'h10, 32'h10, 32'h0, 1'b0, mk("bad_op", M_ALL & ~(M_ALU | M_RD), 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(6'h23, 6'h00, 32'h20, 32'h0, 32'h0, 1'b0, mk("lw20_unwritten", M_LD, 32'h20, 0, 32'h0, 1, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1 vld = 1'b0;
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
